hog_block_assembler: RTL and testbench
======================================

Name: hog_block_assembler

Overview:
- Sits directly upstream of the block normalization stage.
- Receives per-cell histograms one cell at a time, in raster order over a detection window's cell grid.
- Buffers one row of cells and emits each overlapping 2x2 block as the single packed bus the normalizer consumes, with a row-end flag (k_border).
- Also reports frame completion to the descriptor control logic.

Parameters:
- BIN_WIDTH, 14, width of one bin value; the sum bin uses the same width.
- BINS, 9, orientation bins per cell; each cell carries BINS+1 fields, the last being the magnitude sum.
- CELLS_X, 8, cells per grid row (64-pixel window / 8-pixel cells).
- CELLS_Y, 16, cell rows per frame (128-pixel window / 8-pixel cells).
- CELL_WIDTH, BIN_WIDTH*(BINS+1), derived; bits per cell histogram.
- OUT_WIDTH, 4*CELL_WIDTH, derived; bits per block (CELLS_PER_BLOCK fixed at 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  cell_hist is valid this cycle.
- cell_hist  in  CELL_WIDTH  one cell histogram; field j (bin j, j=BINS is the sum) at bits [j*BIN_WIDTH +: BIN_WIDTH].
- out_valid  out  1  block_histograms and k_border are valid.
- k_border  out  1  emitted block is the last block of its block row.
- block_histograms  out  OUT_WIDTH  packed 2x2 block; cell i at [i*CELL_WIDTH +: CELL_WIDTH].
- frame_done  out  1  single-cycle pulse alongside the final block of a frame.

Behaviour:
- Reset (async): out_valid=0, k_border=0, frame_done=0, block_histograms=0, col=0, row=0. Line buffer contents are don't-care; they are never emitted before being rewritten.
- Counters:
  - col in 0..CELLS_X-1 and row in 0..CELLS_Y-1 advance only on in_valid.
  - col wraps at CELLS_X-1 and increments row.
  - row wraps at CELLS_Y-1 to 0, starting a new frame with no idle cycle required.
- Storage:
  - Line buffer of CELLS_X cell entries holding the previous row, indexed by col.
  - prev_cell register holds the current-row cell at col-1.
  - prev_top register holds the line-buffer entry read at col-1.
- On accepted input at (row,col), the block is formed as:
  - cell 0 = prev_top, i.e. (row-1,col-1), top-left.
  - cell 1 = linebuf[col], i.e. (row-1,col), top-right.
  - cell 2 = prev_cell, i.e. (row,col-1), bottom-left.
  - cell 3 = cell_hist, i.e. (row,col), bottom-right.
- In the same edge: linebuf[col] <= cell_hist, prev_cell <= cell_hist, prev_top <= old linebuf[col] (read-before-write).
- Emission:
  - A block is emitted iff in_valid && row>=1 && col>=1.
  - Outputs are registered: out_valid is high exactly one cycle after the accepting edge, for exactly one cycle per block.
- Output registers:
  - block_histograms holds its last value when out_valid=0.
  - k_border=1 with out_valid when col==CELLS_X-1, else 0.
  - frame_done=1 with out_valid when row==CELLS_Y-1 && col==CELLS_X-1.
- Blocks per frame: (CELLS_X-1)*(CELLS_Y-1) = 105 at defaults. There is no output during row 0 or at col 0 of any row.
- Input gaps: in_valid low freezes counters and storage, and out_valid drops the next cycle. Gaps of any length, anywhere, must not change any block's content.
- No backpressure: the downstream stage accepts every out_valid cycle. Full throughput is one cell per clock.
- Reset mid-frame: counters restart at (0,0). The first block after reset appears only once row 1, col 1 is reached, so stale line-buffer data is never emitted.
- Arithmetic: pure data movement; no bin value is modified, truncated, or reordered within a cell.

Test Plan:
- Tagged frame: drive 128 back-to-back cells, each with sum field = row*8+col and bin j = j, other bits 0.
  - Expect exactly 105 out_valid pulses.
  - First block sums (cells 0..3) = 0,1,8,9, with out_valid one cycle after cell (1,1).
  - Last block sums = 118,119,126,127.
- Border flag: in the same run, expect k_border=1 exactly on the 15 blocks whose cell-3 sum is 8r+7 (r=1..15), and 0 on all others.
- Frame wrap: drive two frames back-to-back.
  - frame_done pulses exactly twice, coinciding with the blocks whose cell-3 sum = 127.
  - The second frame's first block again has sums 0,1,8,9, with no mixing of frame-1 data.
- Input gaps: repeat the tagged frame with in_valid deasserted for 3 cycles after every 5 cells. Expect identical block sequence and flags, and out_valid never high on two cycles whose preceding inputs were not both accepted.
- Mid-frame reset: assert rst during cell (5,3), then stream a fresh tagged frame.
  - No out_valid until one cycle after cell (1,1).
  - First block sums = 0,1,8,9.
- Full-width data: fill cells with $random 140-bit values and compare every block bit-exactly against a software model of the 2x2 gather.

Source files
------------

// File: rtl/hog_block_assembler.sv
// hog_block_assembler
// Gathers per-cell HOG histograms, arriving one cell per valid cycle in raster
// order over a CELLS_X x CELLS_Y cell grid, into overlapping 2x2 blocks for the
// block normalizer. The previous cell row is kept in a line buffer.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   in_valid         cell_hist is valid this cycle
//   cell_hist        one cell histogram; field j at [j*BIN_WIDTH +: BIN_WIDTH],
//                    field BINS is the magnitude sum
//   out_valid        block_histograms / k_border / frame_done are valid
//   k_border         emitted block is the last block of its block row
//   block_histograms 2x2 block; cell i at [i*CELL_WIDTH +: CELL_WIDTH]
//                    (0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right)
//   frame_done       pulse alongside the final block of a frame
module hog_block_assembler #(
    parameter int BIN_WIDTH  = 14,
    parameter int BINS       = 9,
    parameter int CELLS_X    = 8,
    parameter int CELLS_Y    = 16,
    parameter int CELL_WIDTH = BIN_WIDTH * (BINS + 1),
    parameter int OUT_WIDTH  = 4 * CELL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [CELL_WIDTH-1:0] cell_hist,
    output logic                  out_valid,
    output logic                  k_border,
    output logic [OUT_WIDTH-1:0]  block_histograms,
    output logic                  frame_done
);

    localparam int COL_W = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
    localparam int ROW_W = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELLS_X - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELLS_Y - 1);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [CELL_WIDTH-1:0] prev_cell_q, prev_cell_d;
    logic [CELL_WIDTH-1:0] prev_top_q, prev_top_d;
    logic [CELL_WIDTH-1:0] linebuf_q [CELLS_X];
    logic [CELL_WIDTH-1:0] linebuf_d [CELLS_X];
    logic                  out_valid_q, out_valid_d;
    logic                  k_border_q, k_border_d;
    logic                  frame_done_q, frame_done_d;
    logic [OUT_WIDTH-1:0]  block_q, block_d;
    logic                  emit;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        prev_cell_d  = prev_cell_q;
        prev_top_d   = prev_top_q;
        linebuf_d    = linebuf_q;
        block_d      = block_q;
        emit         = in_valid && (row_q != '0) && (col_q != '0);
        out_valid_d  = emit;
        k_border_d   = emit && (col_q == COL_LAST);
        frame_done_d = emit && (col_q == COL_LAST) && (row_q == ROW_LAST);

        if (in_valid) begin
            // Read-before-write: the top-right cell and the next prev_top both
            // come from the line buffer entry being overwritten this edge.
            linebuf_d[col_q] = cell_hist;
            prev_cell_d      = cell_hist;
            prev_top_d       = linebuf_q[col_q];
            if (emit) begin
                block_d = {cell_hist, prev_cell_q, linebuf_q[col_q], prev_top_q};
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            k_border_q   <= 1'b0;
            frame_done_q <= 1'b0;
            block_q      <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            k_border_q   <= k_border_d;
            frame_done_q <= frame_done_d;
            block_q      <= block_d;
        end
    end

    // Data-only storage: never emitted before being rewritten after reset
    // (no block before row 1, col 1), so it carries no reset.
    always_ff @(posedge clk) begin
        prev_cell_q <= prev_cell_d;
        prev_top_q  <= prev_top_d;
        linebuf_q   <= linebuf_d;
    end

    assign out_valid        = out_valid_q;
    assign k_border         = k_border_q;
    assign frame_done       = frame_done_q;
    assign block_histograms = block_q;

endmodule

// File: tb/tb_hog_block_assembler.sv
module tb_hog_block_assembler;

    localparam int BW = 14;
    localparam int NB = 9;
    localparam int CX = 8;
    localparam int CY = 16;
    localparam int CW = BW * (NB + 1);
    localparam int OW = 4 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [CW-1:0] cell_hist = '0;
    logic          out_valid;
    logic          k_border;
    logic [OW-1:0] block_histograms;
    logic          frame_done;

    hog_block_assembler #(
        .BIN_WIDTH(BW), .BINS(NB), .CELLS_X(CX), .CELLS_Y(CY)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cell_hist(cell_hist),
        .out_valid(out_valid), .k_border(k_border),
        .block_histograms(block_histograms), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    // Reference model: the whole cell grid of the current frame, addressed by
    // (row, col); each block is simply the 2x2 neighbourhood ending at (r, c).
    logic [CW-1:0] grid [CY][CX];
    int            mr = 0;
    int            mc = 0;
    logic          exp_valid = 1'b0;
    logic          exp_kb = 1'b0;
    logic          exp_fd = 1'b0;
    logic [OW-1:0] exp_block = '0;

    function automatic logic [CW-1:0] tag(input int r, input int c);
        logic [CW-1:0] t;
        t = '0;
        for (int j = 0; j < NB; j++) t[j*BW +: BW] = BW'(j);
        t[NB*BW +: BW] = BW'(r * CX + c);
        return t;
    endfunction

    function automatic logic [CW-1:0] rnd_cell();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[CW-1:0];
    endfunction

    function automatic int sum_of(input logic [OW-1:0] b, input int i);
        return int'(b[i*CW + NB*BW +: BW]);
    endfunction

    function automatic logic [63:0] sums(input logic [OW-1:0] b);
        return {16'(sum_of(b, 3)), 16'(sum_of(b, 2)), 16'(sum_of(b, 1)), 16'(sum_of(b, 0))};
    endfunction

    task automatic model_reset();
        mr = 0; mc = 0;
        exp_valid = 1'b0; exp_kb = 1'b0; exp_fd = 1'b0; exp_block = '0;
    endtask

    // Drives one cycle, advances the model, and returns #1 after the edge.
    task automatic drive(input logic v, input logic [CW-1:0] d);
        in_valid  = v;
        cell_hist = d;
        exp_valid = 1'b0; exp_kb = 1'b0; exp_fd = 1'b0;
        if (v) begin
            grid[mr][mc] = d;
            if (mr >= 1 && mc >= 1) begin
                exp_valid = 1'b1;
                exp_block = {grid[mr][mc], grid[mr][mc-1], grid[mr-1][mc], grid[mr-1][mc-1]};
                exp_kb    = (mc == CX - 1);
                exp_fd    = (mc == CX - 1) && (mr == CY - 1);
            end
            mc++;
            if (mc == CX) begin
                mc = 0;
                mr = (mr == CY - 1) ? 0 : mr + 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, k_border, frame_done} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b expected 000", {out_valid, k_border, frame_done});
        end
        tests_run++;
        if (block_histograms !== '0) begin
            fails++; $display("FAIL reset_block: got %h expected 0", block_histograms);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_tagged_frame();
        int pulses = 0, kbs = 0;
        bit first = 1'b1;
        logic [OW-1:0] last_blk = '0;
        for (int r = 0; r < CY; r++) begin
            for (int c = 0; c < CX; c++) begin
                drive(1'b1, tag(r, c));
                tests_run++;
                if (out_valid !== exp_valid) begin fails++; $display("FAIL tag_valid r%0d c%0d: got %b expected %b", r, c, out_valid, exp_valid); end
                tests_run++;
                if (block_histograms !== exp_block) begin fails++; $display("FAIL tag_block r%0d c%0d: got %h expected %h", r, c, block_histograms, exp_block); end
                tests_run++;
                if ({k_border, frame_done} !== {exp_kb, exp_fd}) begin fails++; $display("FAIL tag_flags r%0d c%0d: got %b expected %b", r, c, {k_border, frame_done}, {exp_kb, exp_fd}); end
                if (out_valid === 1'b1) begin
                    pulses++;
                    if (k_border) kbs++;
                    tests_run++;
                    if (k_border !== ((sum_of(block_histograms, 3) % CX) == CX - 1)) begin
                        fails++; $display("FAIL tag_border_rule sum3=%0d: got %b", sum_of(block_histograms, 3), k_border);
                    end
                    if (first) begin
                        first = 1'b0;
                        tests_run++;
                        if (sums(block_histograms) !== {16'd9, 16'd8, 16'd1, 16'd0}) begin fails++; $display("FAIL tag_first_sums: got %h expected 0009000800010000", sums(block_histograms)); end
                        tests_run++;
                        if (r * CX + c !== 9) begin fails++; $display("FAIL tag_first_latency: got cell %0d expected 9", r * CX + c); end
                    end
                    last_blk = block_histograms;
                end
            end
        end
        tests_run++;
        if (pulses !== 105) begin fails++; $display("FAIL tag_pulses: got %0d expected 105", pulses); end
        tests_run++;
        if (kbs !== 15) begin fails++; $display("FAIL tag_kborder_count: got %0d expected 15", kbs); end
        tests_run++;
        if (sums(last_blk) !== {16'd127, 16'd126, 16'd119, 16'd118}) begin fails++; $display("FAIL tag_last_sums: got %h expected 007f007e00770076", sums(last_blk)); end
    endtask

    task automatic test_frame_wrap();
        int pulses = 0, fds = 0;
        for (int n = 0; n < 2 * CX * CY; n++) begin
            drive(1'b1, tag((n / CX) % CY, n % CX));
            tests_run++;
            if ({out_valid, k_border, frame_done} !== {exp_valid, exp_kb, exp_fd}) begin fails++; $display("FAIL wrap_flags n%0d: got %b expected %b", n, {out_valid, k_border, frame_done}, {exp_valid, exp_kb, exp_fd}); end
            tests_run++;
            if (block_histograms !== exp_block) begin fails++; $display("FAIL wrap_block n%0d: got %h expected %h", n, block_histograms, exp_block); end
            if (out_valid === 1'b1) begin
                if (frame_done) begin
                    fds++;
                    tests_run++;
                    if (sum_of(block_histograms, 3) !== 127) begin fails++; $display("FAIL wrap_fd_cell: got sum3 %0d expected 127", sum_of(block_histograms, 3)); end
                end
                if (pulses == 105) begin
                    tests_run++;
                    if (sums(block_histograms) !== {16'd9, 16'd8, 16'd1, 16'd0}) begin fails++; $display("FAIL wrap_second_first: got %h expected 0009000800010000", sums(block_histograms)); end
                end
                pulses++;
            end
        end
        tests_run++;
        if (fds !== 2) begin fails++; $display("FAIL wrap_fd_count: got %0d expected 2", fds); end
        tests_run++;
        if (pulses !== 210) begin fails++; $display("FAIL wrap_pulses: got %0d expected 210", pulses); end
    endtask

    task automatic test_gaps();
        int pulses = 0, kbs = 0;
        for (int n = 0; n < CX * CY; n++) begin
            for (int g = 0; g < ((n % 5 == 0 && n != 0) ? 3 : 0) + 1; g++) begin
                if (g < ((n % 5 == 0 && n != 0) ? 3 : 0)) drive(1'b0, rnd_cell());
                else drive(1'b1, tag(n / CX, n % CX));
                tests_run++;
                if ({out_valid, k_border, frame_done} !== {exp_valid, exp_kb, exp_fd}) begin fails++; $display("FAIL gap_flags n%0d g%0d: got %b expected %b", n, g, {out_valid, k_border, frame_done}, {exp_valid, exp_kb, exp_fd}); end
                tests_run++;
                if (block_histograms !== exp_block) begin fails++; $display("FAIL gap_block n%0d g%0d: got %h expected %h", n, g, block_histograms, exp_block); end
                if (out_valid === 1'b1) begin
                    pulses++;
                    if (k_border) kbs++;
                end
            end
        end
        tests_run++;
        if (pulses !== 105) begin fails++; $display("FAIL gap_pulses: got %0d expected 105", pulses); end
        tests_run++;
        if (kbs !== 15) begin fails++; $display("FAIL gap_kborder_count: got %0d expected 15", kbs); end
    endtask

    task automatic test_mid_reset();
        int first_cell = -1;
        for (int n = 0; n < 5 * CX + 3; n++) drive(1'b1, tag(n / CX, n % CX));
        in_valid  = 1'b1;
        cell_hist = tag(5, 3);
        rst       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, k_border, frame_done} !== 3'b000 || block_histograms !== '0) begin
            fails++; $display("FAIL midrst_outputs: got flags %b block %h expected 0", {out_valid, k_border, frame_done}, block_histograms);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < CX * CY; n++) begin
            drive(1'b1, tag(n / CX, n % CX));
            tests_run++;
            if ({out_valid, k_border, frame_done} !== {exp_valid, exp_kb, exp_fd}) begin fails++; $display("FAIL midrst_flags n%0d: got %b expected %b", n, {out_valid, k_border, frame_done}, {exp_valid, exp_kb, exp_fd}); end
            tests_run++;
            if (block_histograms !== exp_block) begin fails++; $display("FAIL midrst_block n%0d: got %h expected %h", n, block_histograms, exp_block); end
            if (out_valid === 1'b1 && first_cell < 0) begin
                first_cell = n;
                tests_run++;
                if (sums(block_histograms) !== {16'd9, 16'd8, 16'd1, 16'd0}) begin fails++; $display("FAIL midrst_first_sums: got %h expected 0009000800010000", sums(block_histograms)); end
            end
        end
        tests_run++;
        if (first_cell !== 9) begin fails++; $display("FAIL midrst_first_cell: got %0d expected 9", first_cell); end
    endtask

    task automatic test_random();
        int pulses = 0;
        int n = 0;
        int cyc = 0;
        while (n < 2 * CX * CY && cyc < 2000) begin
            cyc++;
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, rnd_cell());
            end else begin
                drive(1'b1, rnd_cell());
                n++;
            end
            tests_run++;
            if ({out_valid, k_border, frame_done} !== {exp_valid, exp_kb, exp_fd}) begin fails++; $display("FAIL rnd_flags c%0d: got %b expected %b", cyc, {out_valid, k_border, frame_done}, {exp_valid, exp_kb, exp_fd}); end
            tests_run++;
            if (block_histograms !== exp_block) begin fails++; $display("FAIL rnd_block c%0d: got %h expected %h", cyc, block_histograms, exp_block); end
            if (out_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 210) begin fails++; $display("FAIL rnd_pulses: got %0d expected 210", pulses); end
    endtask

    initial begin
        test_reset();
        test_tagged_frame();
        test_frame_wrap();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
